flit_requester: RTL and testbench
=================================

FLIT_REQUESTER -- requirements
Module: flit_requester

Interface
REQ-001 Parameter DATA_W, default 32, flit payload width.
REQ-002 Parameter DEPTH, default 16, flit buffer entries (power of 2); max packet length.
REQ-003 Parameter PKTQ, default 4, buffered complete-packet descriptors.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  source flit valid.
REQ-007 in_ready  out  1  buffer can accept a flit.
REQ-008 in_data  in  DATA_W  source flit payload.
REQ-009 in_last  in  1  marks the last flit of a packet.
REQ-010 grant  in  1  arbiter grant for this port; the one-hot state bit for this port.
REQ-011 req  out  1  request to arbiter.
REQ-012 flit_id  out  3  001 header, 010 body, 100 tail, 000 idle.
REQ-013 length  out  12  flit count of the current packet, stable from header to tail.
REQ-014 flit_data  out  DATA_W  payload of the currently presented flit.

Function
REQ-015 An input flit SHALL be accepted on a cycle with in_valid && in_ready and written to the flit buffer.
REQ-016 in_ready SHALL equal NOT(buffer full) AND NOT(descriptor queue full).
REQ-017 A write counter SHALL count the flits of the packet being written; on the accepted in_last flit, count+1 SHALL be pushed to the descriptor queue and the counter cleared.
REQ-018 FSM states SHALL be IDLE, HEAD, BODY and TAIL; rst forces IDLE.
REQ-019 IDLE: req=0, flit_id=000; go to HEAD when the descriptor queue is non-empty, latching the descriptor into length and a remaining counter.
REQ-020 HEAD/BODY/TAIL: req=1, flit_id=001/010/100 respectively, flit_data=buffer head.
REQ-021 A flit SHALL be consumed (buffer pop, remaining decremented) only on a cycle with req && grant.
REQ-022 On HEAD consume: remaining==1 -> IDLE (header-only packet); remaining==2 -> TAIL; otherwise BODY.
REQ-023 On BODY consume: -> TAIL when remaining after the decrement equals 1.
REQ-024 On TAIL consume: pop the descriptor and go to IDLE; a next descriptor SHALL be taken no earlier than the following cycle, so req drops for at least one cycle between packets.
REQ-025 When grant is low mid-packet (arbiter timeout or preemption), the FSM SHALL hold its state, flit_id, flit_data and length, and keep req=1 until grant returns.
REQ-026 A simultaneous write and pop on a full buffer SHALL be accepted only if in_ready was high; pointers wrap modulo DEPTH.
REQ-027 Outputs SHALL be registered or derived only from registered state; there is no combinational path from grant to req.
REQ-028 Packets longer than DEPTH flits are unsupported; a simulation-only assertion SHALL flag a write counter reaching DEPTH.

Reset
REQ-029 On rst: buffer pointers, counters, descriptor queue and FSM cleared.
REQ-030 On rst: req=0, flit_id=000, length=0, flit_data=0, in_ready=1 in the first cycle after reset.
REQ-031 rst mid-packet SHALL discard all buffered and in-flight flits, with no tail emitted.

Structure
REQ-032 The shared package SHALL hold the flit_id constants (FLIT_IDLE, FLIT_HEAD, FLIT_BODY, FLIT_TAIL), the FSM state encoding and the 12-bit length width.
REQ-033 One sub-module, flit_fifo (synchronous FIFO, parameterised width and depth), SHALL be instantiated twice: once for flits and once for descriptors.

Verification
REQ-034 Push a 4-flit packet (A,B,C,D; D last), grant held high -> headers: length=4, flit_id 001,010,010,100 with data A..D on consecutive cycles, then req=0.
REQ-035 Push a 1-flit packet -> one cycle of flit_id=001, length=1, then IDLE with no tail.
REQ-036 Push a 3-flit packet and drop grant for 3 cycles after the header -> body flit held stable with req=1; resumes on grant; total 3 flits delivered, none lost or duplicated.
REQ-037 Push 16 flits with no grant -> in_ready=0 on the cycle after the 16th accept; grant then drains in order and in_ready rises after the first pop.
REQ-038 Push two back-to-back 2-flit packets -> req low for at least one cycle between tail and the second header; second header has length=2.
REQ-039 Assert rst during a BODY flit -> next cycle req=0, flit_id=000; a fresh 2-flit packet then sends normally.

Source files
------------

// File: rtl/flit_requester_pkg.sv
// flit_requester_pkg: flit id codes, FSM state encoding and length width shared by flit_requester
package flit_requester_pkg;
  localparam int LEN_W = 12;
  localparam logic [2:0] FLIT_IDLE = 3'b000;
  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous FIFO with show-ahead head; ports clk, rst, push/din, pop/dout, full, empty
module flit_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  // extra pointer bit separates full from empty when the indices match
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/flit_requester.sv
// flit_requester: buffers source packets and presents them flit by flit to an arbiter
// ports: clk, rst; source in_valid/in_ready/in_data/in_last; arbiter grant/req;
//        presented flit flit_id (001 head, 010 body, 100 tail, 000 idle), length, flit_data
import flit_requester_pkg::*;
module flit_requester #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int PKTQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  output logic [DATA_W-1:0] flit_data
);
  state_t state, state_nx;
  logic [LEN_W-1:0] wr_cnt, rem, desc;
  logic [DATA_W-1:0] head;
  logic buf_full, buf_empty, dq_full, dq_empty, accept, consume, last_flit;
  assign in_ready = !buf_full && !dq_full;
  assign accept = in_valid && in_ready;
  assign consume = req && grant;
  // the descriptor is retired with the final flit, including a header-only packet
  assign last_flit = (state == S_TAIL) || (state == S_HEAD && rem == LEN_W'(1));
  flit_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .push(accept), .pop(consume), .din(in_data),
    .dout(head), .full(buf_full), .empty(buf_empty)
  );
  flit_fifo #(.W(LEN_W), .DEPTH(PKTQ)) u_desc (
    .clk(clk), .rst(rst), .push(accept && in_last), .pop(consume && last_flit),
    .din(wr_cnt + 1'b1), .dout(desc), .full(dq_full), .empty(dq_empty)
  );
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = dq_empty ? S_IDLE : S_HEAD;
      S_HEAD: if (consume) state_nx = rem == LEN_W'(1) ? S_IDLE : rem == LEN_W'(2) ? S_TAIL : S_BODY;
      S_BODY: if (consume && rem == LEN_W'(2)) state_nx = S_TAIL;
      S_TAIL: if (consume) state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    req = state != S_IDLE;
    flit_id = state == S_HEAD ? FLIT_HEAD : state == S_BODY ? FLIT_BODY : state == S_TAIL ? FLIT_TAIL : FLIT_IDLE;
    flit_data = req ? head : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_cnt <= '0;
      length <= '0;
      rem <= '0;
    end else begin
      if (accept) wr_cnt <= in_last ? '0 : wr_cnt + 1'b1;
      if (state == S_IDLE && !dq_empty) begin
        length <= desc;
        rem <= desc;
      end else if (consume) rem <= rem - 1'b1;
    end
  // packets longer than the buffer cannot be delivered
  always_ff @(posedge clk)
    if (!rst) begin
      assert (wr_cnt < LEN_W'(DEPTH));
      assert (!(consume && buf_empty));
    end
endmodule

// File: tb/tb_flit_requester.sv
// tb_flit_requester: directed and randomized checks of flit_requester against a packet-level model
import flit_requester_pkg::*;
module tb_flit_requester;
  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [11:0] len;
  } flit_t;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, grant = 0;
  logic [31:0] in_data = '0;
  logic in_ready, req;
  logic [2:0] flit_id;
  logic [11:0] length;
  logic [31:0] flit_data;
  int vectors = 0, errors = 0;
  flit_t exp_q[$];
  logic [31:0] cur[$];
  bit gap = 0;
  logic [2:0] ids4 [4];

  flit_requester dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .grant(grant), .req(req), .flit_id(flit_id), .length(length),
    .flit_data(flit_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // model: complete packets become a queue of expected flits; each cycle with req the
  // front flit must be presented, and a granted cycle retires it
  task automatic tick();
    flit_t f;
    int n;
    if (rst) begin
      exp_q.delete();
      cur.delete();
      gap = 0;
    end else begin
      if (gap) chk("gap_after_tail", req, 0);
      gap = 0;
      if (req) begin
        chk("req_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          f = exp_q[0];
          chk("flit_id", flit_id, f.id);
          chk("flit_data", flit_data, f.data);
          chk("length", length, f.len);
          if (grant) begin
            void'(exp_q.pop_front());
            gap = f.id == FLIT_TAIL || f.len == 1;
          end
        end
      end else chk("idle_id", flit_id, FLIT_IDLE);
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (in_last) begin
          n = cur.size();
          foreach (cur[i]) begin
            f.id = i == 0 ? FLIT_HEAD : i == n - 1 ? FLIT_TAIL : FLIT_BODY;
            f.data = cur[i];
            f.len = 12'(n);
            exp_q.push_back(f);
          end
          cur.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_pkt(int n, logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      in_valid = 1;
      in_data = base == 0 ? $urandom : base + i;
      in_last = i == n - 1;
      while (!in_ready && k < 100) begin
        tick();
        k++;
      end
      chk("wr_ready", in_ready, 1);
      tick();
    end
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!req && k < 50) begin
      tick();
      k++;
    end
    chk("wait_req", req, 1);
  endtask

  task automatic drain();
    int k = 0;
    grant = 1;
    while ((exp_q.size() != 0 || req) && k < 300) begin
      tick();
      k++;
    end
    chk("drained", exp_q.size(), 0);
    chk("drain_req", req, 0);
  endtask

  initial begin
    ids4 = '{FLIT_HEAD, FLIT_BODY, FLIT_BODY, FLIT_TAIL};
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    chk("rst_req", req, 0);
    chk("rst_id", flit_id, FLIT_IDLE);
    chk("rst_len", length, 0);
    chk("rst_data", flit_data, 0);
    chk("rst_ready", in_ready, 1);

    // 4-flit packet, grant held: consecutive header/body/body/tail
    wr_pkt(4, 32'hA0);
    wait_req();
    grant = 1;
    for (int i = 0; i < 4; i++) begin
      chk("p4_id", flit_id, ids4[i]);
      chk("p4_data", flit_data, 32'hA0 + i);
      chk("p4_len", length, 4);
      tick();
    end
    chk("p4_end_req", req, 0);
    grant = 0;

    // header-only packet
    wr_pkt(1, 32'h50);
    wait_req();
    chk("p1_id", flit_id, FLIT_HEAD);
    chk("p1_len", length, 1);
    grant = 1;
    tick();
    chk("p1_req", req, 0);
    chk("p1_no_tail", flit_id, FLIT_IDLE);
    tick();
    chk("p1_idle", req, 0);
    grant = 0;

    // grant withdrawn for 3 cycles after the header
    wr_pkt(3, 32'h30);
    wait_req();
    grant = 1;
    tick();
    grant = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", req, 1);
      chk("hold_id", flit_id, FLIT_BODY);
      chk("hold_data", flit_data, 32'h31);
      chk("hold_len", length, 3);
      tick();
    end
    drain();

    // fill the buffer with no grant
    grant = 0;
    wr_pkt(16, 32'h100);
    chk("full_ready", in_ready, 0);
    wait_req();
    grant = 1;
    tick();
    chk("pop_ready", in_ready, 1);
    drain();

    // back-to-back 2-flit packets
    grant = 1;
    wr_pkt(2, 0);
    wr_pkt(2, 0);
    drain();

    // reset in the middle of a body flit
    grant = 0;
    wr_pkt(3, 32'h70);
    wait_req();
    grant = 1;
    tick();
    chk("pre_rst_id", flit_id, FLIT_BODY);
    rst = 1;
    tick();
    rst = 0;
    chk("post_rst_req", req, 0);
    chk("post_rst_id", flit_id, FLIT_IDLE);
    chk("post_rst_ready", in_ready, 1);
    wr_pkt(2, 32'h80);
    drain();

    // randomized traffic with random grant
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_data = $urandom;
      in_last = cur.size() == 7 || $urandom_range(0, 3) == 0;
      grant = $urandom_range(0, 2) != 0;
      tick();
    end
    in_valid = 0;
    wr_pkt(1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
